// File: rtl/alu_pkg.sv
// Shared opcodes and FSM states for the sequential ALU.
// Imported by alu_seq and mul_div_iter.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic is_iter(
    input logic [3:0] op
  );
    return (op == OP_MUL) ||
           (op == OP_DIVU) ||
           (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier and restoring divider.
// One step per cycle, WIDTH steps per op.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    count;
  logic [3:0]       op_q;
  // p: product / partial remainder
  // x: multiplicand / dividend-quotient
  // y: multiplier / divisor
  logic [WIDTH-1:0] p, x, y;
  logic [WIDTH-1:0] p_nx, x_nx, y_nx;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    r    = {p, x[WIDTH-1]};
    diff = r[WIDTH-1:0] - y;
    ge   = r >= {1'b0, y};
    if (op_q == OP_MUL) begin
      p_nx = p + (y[0] ? x : '0);
      x_nx = x << 1;
      y_nx = y >> 1;
    end else begin
      p_nx = ge ? diff : r[WIDTH-1:0];
      x_nx = {x[WIDTH-2:0], ge};
      y_nx = y;
    end
  end

  assign done = count == CW'(1);
  assign res  = (op_q == OP_DIVU) ? x_nx : p_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      op_q  <= '0;
      p     <= '0;
      x     <= '0;
      y     <= '0;
    end else if (start) begin
      count <= CW'(WIDTH);
      op_q  <= op;
      p     <= '0;
      x     <= a;
      y     <= b;
    end else if (count != '0) begin
      count <= count - CW'(1);
      p     <= p_nx;
      x     <= x_nx;
      y     <= y_nx;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle ops,
// iterative MUL/DIVU/REMU via mul_div_iter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [3:0]       ALUcontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Invalid
);

  state_t           state, state_nx;
  logic             accept, iter;
  logic             md_done, alu_inv;
  logic [WIDTH-1:0] md_res, alu_res;
  logic [SHW-1:0]   sh;

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign iter      = is_iter(ALUcontrol);
  assign sh        = I2[SHW-1:0];
  assign Zero      = Result == '0;

  always_comb begin
    alu_res = '0;
    alu_inv = 1'b0;
    unique case (1'b1)
      ALUcontrol == OP_ADD:  alu_res = I1 + I2;
      ALUcontrol == OP_SUB:  alu_res = I1 - I2;
      ALUcontrol == OP_AND:  alu_res = I1 & I2;
      ALUcontrol == OP_OR:   alu_res = I1 | I2;
      ALUcontrol == OP_XOR:  alu_res = I1 ^ I2;
      ALUcontrol == OP_SLL:  alu_res = I1 << sh;
      ALUcontrol == OP_SRL:  alu_res = I1 >> sh;
      ALUcontrol == OP_SRA:
        alu_res = $signed(I1) >>> sh;
      ALUcontrol == OP_SLT:
        alu_res = {{(WIDTH-1){1'b0}},
                   $signed(I1) < $signed(I2)};
      ALUcontrol == OP_SLTU:
        alu_res = {{(WIDTH-1){1'b0}}, I1 < I2};
      iter:                  alu_res = '0;
      default:               alu_inv = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept) state_nx = iter ? BUSY : DONE;
      BUSY:
        if (md_done) state_nx = DONE;
      DONE:
        if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Result  <= '0;
      Invalid <= 1'b0;
    end else if (accept) begin
      Invalid <= alu_inv;
      if (!iter) Result <= alu_res;
    end else if (state == BUSY && md_done) begin
      Result <= md_res;
    end
  end

  mul_div_iter #(
    .WIDTH(WIDTH)
  ) u_md (
    .clk  (clk),
    .reset(reset),
    .start(accept && iter),
    .op   (ALUcontrol),
    .a    (I1),
    .b    (I2),
    .done (md_done),
    .res  (md_res)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal
// cases plus randomized traffic against a reference model.
module tb_alu_seq;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic         out_valid, out_ready;
  logic [W-1:0] I1, I2, Result;
  logic [3:0]   ALUcontrol;
  logic         Zero, Invalid;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I1        (I1),
    .I2        (I2),
    .ALUcontrol(ALUcontrol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Invalid   (Invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference: ops straight from their arithmetic meaning
  function automatic void model(
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         inv,
    output int           lat
  );
    int n;
    n   = int'(b % W);
    r   = '0;
    inv = 1'b0;
    lat = 1;
    case (op)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0100: r = a << n;
      4'b0101: r = a >> n;
      4'b1000: r = $signed(a) >>> n;
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1001: r = (a < b) ? 1 : 0;
      4'b1010: begin r = a * b; lat = W + 1; end
      4'b1100: begin
        r = (b == 0) ? '1 : a / b;
        lat = W + 1;
      end
      4'b1101: begin
        r = (b == 0) ? a : a % b;
        lat = W + 1;
      end
      default: inv = 1'b1;
    endcase
  endfunction

  // Compare process: every cycle after the first reset edge
  bit           armed = 0;
  bit           pending = 0;
  bit           exp_ov;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           lat_q = 1;
  logic [W-1:0] er;
  logic         ei;

  always @(negedge clk) begin
    exp_ov = pending && (cyc - acc_cyc >= lat_q);
    if (armed) begin
      chk("mon in_ready", in_ready, !pending);
      chk("mon out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("mon result", Result, er);
        chk("mon zero", Zero, er == '0);
        chk("mon invalid", Invalid, ei);
      end
    end
    if (reset) begin
      pending = 0;
      armed   = 1;
    end else if (armed) begin
      if (pending && exp_ov && out_ready) begin
        pending = 0;
      end else if (!pending && in_valid) begin
        model(ALUcontrol, I1, I2, er, ei, lat_q);
        pending = 1;
        acc_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic chk_reset();
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", Result, 0);
    chk("rst zero", Zero, 1);
    chk("rst invalid", Invalid, 0);
  endtask

  task automatic run_op(
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  int           hold,
    output logic [W-1:0] r,
    output logic         z,
    output logic         inv,
    output int           lat,
    output int           rdy_seen
  );
    int guard = 0;
    rdy_seen = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("idle before op", in_ready, 1);
    ALUcontrol = op;
    I1 = a;
    I2 = b;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    I1 = {$urandom, $urandom};
    I2 = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < W + 20) begin
      if (in_ready) rdy_seen++;
      @(posedge clk); #1;
      lat++;
    end
    r   = Result;
    z   = Zero;
    inv = Invalid;
    for (int k = 0; k < hold; k++) begin
      in_valid   = 1;
      ALUcontrol = 4'b0011;
      @(posedge clk); #1;
      chk("hold result", Result, r);
      chk("hold out_valid", out_valid, 1);
      chk("hold in_ready", in_ready, 0);
    end
    in_valid  = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("in_ready after pop", in_ready, 1);
  endtask

  task automatic dir(input string name,
                     input logic [3:0] op,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] er_l,
                     input logic ez_l,
                     input logic ei_l,
                     input int el_l);
    logic [W-1:0] r;
    logic         z, inv;
    int           lat, rdy;
    run_op(op, a, b, 0, r, z, inv, lat, rdy);
    chk({name, " result"}, r, er_l);
    chk({name, " zero"}, z, ez_l);
    chk({name, " invalid"}, inv, ei_l);
    chk({name, " latency"}, lat, el_l);
    chk({name, " busy ready"}, rdy, 0);
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom % 4)
      0:       return W'($urandom % 20);
      1:       return {$urandom, $urandom};
      2:       return '1 - W'($urandom % 4);
      default: return {1'b1, 31'($urandom), $urandom};
    endcase
  endfunction

  initial begin
    logic [W-1:0] r;
    logic         z, inv;
    int           lat, rdy;

    reset = 1; in_valid = 0; out_ready = 0;
    I1 = '0; I2 = '0; ALUcontrol = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_reset();

    dir("add", 4'b0010, 5, 7, 12, 0, 0, 1);
    dir("sub", 4'b0110, 5, 5, 0, 1, 0, 1);
    dir("mul", 4'b1010, 3, 64'hFFFF_FFFF_FFFF_FFFE,
        64'hFFFF_FFFF_FFFF_FFFA, 0, 0, W + 1);
    dir("divu", 4'b1100, 100, 7, 14, 0, 0, W + 1);
    dir("remu", 4'b1101, 100, 7, 2, 0, 0, W + 1);
    dir("divu0", 4'b1100, 9, 0, '1, 0, 0, W + 1);
    dir("remu0", 4'b1101, 9, 0, 9, 0, 0, W + 1);
    dir("sra", 4'b1000, 64'h8000_0000_0000_0000,
        64'h41, 64'hC000_0000_0000_0000, 0, 0, 1);
    dir("slt", 4'b0111, '1, 1, 1, 0, 0, 1);
    dir("sltu", 4'b1001, '1, 1, 0, 1, 0, 1);
    dir("bad op", 4'b1111, 3, 4, 0, 1, 1, 1);

    run_op(4'b0010, 1, 2, 10, r, z, inv, lat, rdy);
    chk("hold op result", r, 3);

    // Reset in BUSY cycle 20 of a MUL
    ALUcontrol = 4'b1010;
    I1 = 3; I2 = 5;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (19) @(posedge clk);
    #1 chk("busy before reset", in_ready, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk_reset();
    for (int k = 0; k < W + 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) chk("ghost out_valid", out_valid, 0);
    end
    chk("after reset idle", in_ready, 1);

    for (int c = 0; c < 6000; c++) begin
      in_valid   = ($urandom % 3) != 0;
      ALUcontrol = 4'($urandom_range(0, 15));
      I1         = rnd();
      I2         = rnd();
      out_ready  = ($urandom % 4) != 0;
      reset      = ($urandom % 1000) == 0;
      @(posedge clk); #1;
    end
    reset     = 0;
    in_valid  = 0;
    out_ready = 1;
    repeat (W + 5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational 64-bit ALU. Used in the multi-cycle datapath lab.
- Executes single-cycle logic, arithmetic, shift and compare ops with a registered result.
- Executes iterative multiply, divide and remainder over WIDTH cycles.
- Sits between operand fetch and writeback. Uses valid/ready on both sides.

Parameters:
- WIDTH, 64: operand/result width. Power of two, 8 to 64.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and ALUcontrol valid
- in_ready  out  1  block can accept an op
- I1  in  WIDTH  operand 1
- I2  in  WIDTH  operand 2
- ALUcontrol  in  4  opcode
- out_valid  out  1  Result, Zero and Invalid valid
- out_ready  in  1  consumer accepts the result
- Result  out  WIDTH  result
- Zero  out  1  1 when Result == 0
- Invalid  out  1  unsupported opcode

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Opcodes, single-cycle:
  - 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR
  - 0100 SLL, 0101 SRL, 1000 SRA: shift by I2[SHW-1:0]
  - 0111 SLT (signed), 1001 SLTU: Result = {0..0, flag}
- Opcodes, iterative:
  - 1010 MUL: low WIDTH bits of the product
  - 1100 DIVU: unsigned quotient
  - 1101 REMU: unsigned remainder
- All other opcodes: Result=0, Zero=1, Invalid=1. Latency is the same as single-cycle ops. Never X.
- ADD/SUB wrap modulo 2^WIDTH. No overflow flag.
- DIVU/REMU with I2==0: quotient all ones, remainder = I1.
- Zero is computed from the registered Result in every case.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture operands and opcode. Single-cycle or invalid op: go to DONE next cycle with the result registered. Iterative op: go to BUSY and load count = WIDTH.
  - BUSY: in_ready=0. One shift-add or restoring-subtract step per cycle; count decrements. When count reaches 1, the final step completes and the FSM goes to DONE.
  - DONE: out_valid=1. Result, Zero and Invalid are held stable until out_ready. On out_ready, go to IDLE; in_ready rises the next cycle.
- Latency, with acceptance in cycle N:
  - single-cycle op: out_valid in N+1
  - iterative op: out_valid in N+WIDTH+1
- Throughput: one op per 2 cycles at best. There is no accept-while-DONE path.
- Backpressure: out_valid and the outputs hold indefinitely while out_ready=0.
- Input side: in_valid while in_ready=0 is ignored. Operands are sampled only on acceptance.
- Reset values: state=IDLE, in_ready=1 in the first cycle after reset, out_valid=0, Result=0, Zero=1, Invalid=0, count=0.
- Reset mid-op: an in-flight BUSY or DONE op is discarded and produces no out_valid.

Decomposition:
- alu_pkg holds:
  - the opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_MUL, OP_DIVU, OP_REMU)
  - the FSM state enum {IDLE, BUSY, DONE}
- One sub-module: mul_div_iter.
  - Parametrised by WIDTH.
  - Interface: start, op, a, b; returns done and res.
  - Contains the shift-add multiplier, the restoring divider and the counter.
- The top level holds the FSM, the single-cycle ALU and the output registers.

Test Plan:
- ADD 5+7, then SUB 5-5, WIDTH=64 -> Result=12, Zero=0 at N+1; then Result=0, Zero=1 at N+1.
- MUL 3 x 0xFFFF_FFFF_FFFF_FFFE -> Result=0xFFFF_FFFF_FFFF_FFFA, out_valid exactly at N+65, in_ready=0 for cycles N+1..N+65.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> all ones; REMU 9/0 -> 9.
- SRA 0x8000_0000_0000_0000 by I2=0x41 (shift 1) -> 0xC000_0000_0000_0000; SLT -1<1 -> 1; SLTU -1<1 -> 0.
- Hold out_ready=0 for 10 cycles after out_valid -> Result stable and no new accept; pulse out_ready -> in_ready=1 next cycle.
- Opcode 1111 -> Result=0, Invalid=1. Assert reset at BUSY cycle 20 of MUL -> out_valid never rises for that op; all reset values hold next cycle.
